// File: rtl/song_format_pkg.sv
// Song word format shared by the song recorder and song reader.
// Build option: SONG_RECORDER_GAP_REST_EN (defined = gaps between notes are recorded as rests).
package song_format_pkg;

    localparam int TYPE_BIT   = 15;
    localparam int NOTE_MSB   = 14;
    localparam int NOTE_LSB   = 9;
    localparam int DUR_MSB    = 8;
    localparam int DUR_LSB    = 3;

    localparam logic WORD_NOTE = 1'b0;
    localparam logic WORD_WAIT = 1'b1;

    localparam logic [15:0] END_WORD = 16'h0000;
    localparam int          SONG_WORDS = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_HELD,
        ST_GAP,
        ST_WR_NOTE,
        ST_WR_WAIT,
        ST_WR_REST,
        ST_TERM
    } rec_state_t;

    // Pack a type bit, note and duration into one song word; the low bits stay zero.
    function automatic logic [15:0] make_word(input logic word_type,
                                              input logic [5:0] note,
                                              input logic [5:0] dur);
        logic [15:0] w;
        w = 16'h0000;
        w[TYPE_BIT]          = word_type;
        w[NOTE_MSB:NOTE_LSB] = note;
        w[DUR_MSB:DUR_LSB]   = dur;
        return w;
    endfunction

endpackage

// File: rtl/beat_interval_counter.sv
// Saturating beat counter for the interval being timed, plus key_down edge detection.
// Build option: SONG_RECORDER_GAP_REST_EN (no effect on this block).
module beat_interval_counter #(
    parameter int MAX_DUR = 63
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       beat,
    input  logic       clear,
    input  logic       key_down,
    output logic [5:0] interval,
    output logic       key_rise,
    output logic       key_fall
);

    localparam logic [5:0] MAX_V = 6'(MAX_DUR);

    logic [5:0] cnt_q, cnt_d;
    logic       key_q, key_d;

    // Interval length including a beat arriving this cycle, then the next counter value.
    always_comb begin
        interval = cnt_q;
        if (beat) begin
            interval = (cnt_q >= MAX_V) ? MAX_V : cnt_q + 6'd1;
        end
        cnt_d    = clear ? 6'd0 : interval;
        key_d    = key_down;
        key_rise = key_down & ~key_q;
        key_fall = ~key_down & key_q;
    end

    // Counter and previous key level registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= 6'd0;
            key_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            key_q <= key_d;
        end
    end

endmodule

// File: rtl/song_recorder.sv
// Captures monophonic key presses and writes them as song words into the selected song slot.
// Build option: SONG_RECORDER_GAP_REST_EN (defined = silent gaps between notes become rest words).
module song_recorder
    import song_format_pkg::*;
#(
    parameter int INDEX_WIDTH = 5,
    parameter int MAX_DUR     = 63
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     beat,
    input  logic                     play,
    input  logic                     record_button,
    input  logic [1:0]               song,
    input  logic                     key_down,
    input  logic [5:0]               key_note,
    output logic                     wr_en,
    output logic [2+INDEX_WIDTH-1:0] wr_addr,
    output logic [15:0]              wr_data,
    output logic                     recording,
    output logic                     record_done,
    output logic                     overflow
);

    // The last slot index is kept for the terminator, so a note+wait pair must start below LAST_IDX-1.
    localparam logic [INDEX_WIDTH-1:0] LAST_IDX   = '1;
    localparam logic [INDEX_WIDTH-1:0] PAIR_LIMIT = LAST_IDX - {{(INDEX_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [INDEX_WIDTH-1:0] IDX_ONE    = {{(INDEX_WIDTH-1){1'b0}}, 1'b1};

    rec_state_t               state_q, state_d;
    logic [1:0]               slot_q, slot_d;
    logic [INDEX_WIDTH-1:0]   index_q, index_d;
    logic [5:0]               note_q, note_d;
    logic [5:0]               dur_q, dur_d;
    logic                     stop_q, stop_d;
    logic                     overflow_q, overflow_d;
    logic                     recording_q, recording_d;
    logic                     record_done_q, record_done_d;
    logic                     wr_en_q, wr_en_d;
    logic [2+INDEX_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [15:0]              wr_data_q, wr_data_d;

    logic       cnt_clear;
    logic [5:0] interval;
    logic       key_rise;
    logic       key_fall;
    logic       btn;

    beat_interval_counter #(
        .MAX_DUR (MAX_DUR)
    ) u_counter (
        .clk      (clk),
        .reset    (reset),
        .beat     (beat),
        .clear    (cnt_clear),
        .key_down (key_down),
        .interval (interval),
        .key_rise (key_rise),
        .key_fall (key_fall)
    );

    // Next-state logic: the counter only runs while timing a held note or a gap.
    always_comb begin
        state_d       = state_q;
        slot_d        = slot_q;
        index_d       = index_q;
        note_d        = note_q;
        dur_d         = dur_q;
        stop_d        = stop_q;
        overflow_d    = overflow_q;
        recording_d   = recording_q;
        record_done_d = 1'b0;
        wr_en_d       = 1'b0;
        wr_addr_d     = wr_addr_q;
        wr_data_d     = wr_data_q;
        cnt_clear     = 1'b1;
        btn           = record_button & ~play;

        case (state_q)
            ST_IDLE: begin
                if (btn) begin
                    slot_d      = song;
                    index_d     = '0;
                    overflow_d  = 1'b0;
                    stop_d      = 1'b0;
                    recording_d = 1'b1;
                    state_d     = ST_ARMED;
                end
            end

            ST_ARMED: begin
                if (btn) begin
                    state_d = ST_TERM;
                end else if (key_rise) begin
                    note_d  = key_note;
                    state_d = ST_HELD;
                end
            end

            ST_HELD: begin
                cnt_clear = 1'b0;
                if (btn || key_fall) begin
                    dur_d   = (interval == 6'd0) ? 6'd1 : interval;
                    stop_d  = btn;
                    state_d = ST_WR_NOTE;
                end
            end

            ST_WR_NOTE: begin
                if (btn) begin
                    stop_d = 1'b1;
                end
                if (index_q >= PAIR_LIMIT) begin
                    overflow_d = 1'b1;
                    state_d    = ST_TERM;
                end else begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = {slot_q, index_q};
                    wr_data_d = make_word(WORD_NOTE, note_q, dur_q);
                    index_d   = index_q + IDX_ONE;
                    state_d   = ST_WR_WAIT;
                end
            end

            ST_WR_WAIT: begin
                wr_en_d   = 1'b1;
                wr_addr_d = {slot_q, index_q};
                wr_data_d = make_word(WORD_WAIT, 6'd0, dur_q);
                index_d   = index_q + IDX_ONE;
                state_d   = (stop_q || btn) ? ST_TERM : ST_GAP;
            end

            ST_GAP: begin
                cnt_clear = 1'b0;
                if (btn) begin
                    state_d = ST_TERM;
                end else if (key_rise) begin
                    note_d    = key_note;
                    cnt_clear = 1'b1;
`ifdef SONG_RECORDER_GAP_REST_EN
                    if (interval != 6'd0) begin
                        dur_d   = interval;
                        state_d = ST_WR_REST;
                    end else begin
                        state_d = ST_HELD;
                    end
`else
                    state_d = ST_HELD;
`endif
                end
            end

`ifdef SONG_RECORDER_GAP_REST_EN
            ST_WR_REST: begin
                if (index_q == LAST_IDX) begin
                    overflow_d = 1'b1;
                    state_d    = ST_TERM;
                end else begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = {slot_q, index_q};
                    wr_data_d = make_word(WORD_WAIT, 6'd0, dur_q);
                    index_d   = index_q + IDX_ONE;
                    state_d   = (stop_q || btn) ? ST_TERM : ST_HELD;
                end
            end
`endif

            ST_TERM: begin
                wr_en_d       = 1'b1;
                wr_addr_d     = {slot_q, index_q};
                wr_data_d     = END_WORD;
                record_done_d = 1'b1;
                recording_d   = 1'b0;
                stop_d        = 1'b0;
                state_d       = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Recorder state and registered outputs; reset abandons any partial song.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            slot_q        <= 2'd0;
            index_q       <= '0;
            note_q        <= 6'd0;
            dur_q         <= 6'd0;
            stop_q        <= 1'b0;
            overflow_q    <= 1'b0;
            recording_q   <= 1'b0;
            record_done_q <= 1'b0;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= 16'h0000;
        end else begin
            state_q       <= state_d;
            slot_q        <= slot_d;
            index_q       <= index_d;
            note_q        <= note_d;
            dur_q         <= dur_d;
            stop_q        <= stop_d;
            overflow_q    <= overflow_d;
            recording_q   <= recording_d;
            record_done_q <= record_done_d;
            wr_en_q       <= wr_en_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
        end
    end

    assign wr_en       = wr_en_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign recording   = recording_q;
    assign record_done = record_done_q;
    assign overflow    = overflow_q;

endmodule
